// File: rtl/fpga_io_pkg.sv
// Shared types and sizing helpers for the board-side I/O conditioner.
package fpga_io_pkg;

  localparam int unsigned LOCK_CNT_W = 8;

  typedef enum logic [1:0] {
    HOLD,
    COUNT,
    RUN
  } rst_state_e;

  // Bits needed for a counter that must be able to hold max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/fpga_io_conditioner_debounce.sv
// Single-channel synchroniser + debouncer with registered level and edge pulses.
module io_debounce
  import fpga_io_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned DEBOUNCE_CYC = 1000,
  parameter logic        RST_VAL      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic ch_i,
  output logic ch_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned       CNT_W    = cnt_width(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [CNT_W-1:0]       cnt_q;
  logic                   s;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= {SYNC_STAGES{RST_VAL}};
      cnt_q  <= '0;
      ch_o   <= RST_VAL;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], ch_i};
      rise_o <= 1'b0;
      fall_o <= 1'b0;
      if (s == ch_o) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        ch_o   <= s;
        cnt_q  <= '0;
        rise_o <= s;
        fall_o <= ~s;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/fpga_io_conditioner.sv
// Reset sequencer (lock-qualified SoC reset) plus NUM_CH debounced board inputs.
module fpga_io_conditioner
  import fpga_io_pkg::*;
#(
  parameter int unsigned       NUM_CH       = 3,
  parameter int unsigned       SYNC_STAGES  = 2,
  parameter int unsigned       DEBOUNCE_CYC = 1000,
  parameter int unsigned       RST_HOLD_CYC = 16,
  parameter logic [NUM_CH-1:0] CH_RST_VAL   = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  pll_locked_i,
  input  logic [NUM_CH-1:0]     ch_i,
  output logic [NUM_CH-1:0]     ch_o,
  output logic [NUM_CH-1:0]     rise_o,
  output logic [NUM_CH-1:0]     fall_o,
  output logic                  sys_rst_n_o,
  output logic [LOCK_CNT_W-1:0] lock_loss_cnt_o
);

  localparam int unsigned          HOLD_W    = cnt_width(RST_HOLD_CYC);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_HOLD_CYC - 1);

  logic [1:0]             rst_sync_q;
  logic                   rst_n;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  rst_state_e             state_q, state_d;
  logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
  logic                   lock_lost;

  // Asynchronous assert, clk-synchronous release for everything below.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) rst_sync_q <= '0;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) lock_sync_q <= '0;
    else        lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], pll_locked_i};
  end
  assign lock_s = lock_sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    lock_lost  = 1'b0;
    case (state_q)
      HOLD: begin
        hold_cnt_d = '0;
        if (lock_s) state_d = COUNT;
      end
      COUNT: begin
        if (!lock_s) begin
          state_d    = HOLD;
          hold_cnt_d = '0;
        end else if (hold_cnt_q == HOLD_LAST) begin
          state_d    = RUN;
          hold_cnt_d = '0;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d   = HOLD;
          lock_lost = 1'b1;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  // sys_rst_n_o registers the next state so it tracks RUN entry/exit on the same edge.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= HOLD;
      hold_cnt_q      <= '0;
      sys_rst_n_o     <= 1'b0;
      lock_loss_cnt_o <= '0;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      sys_rst_n_o <= (state_d == RUN);
      if (lock_lost && (lock_loss_cnt_o != '1))
        lock_loss_cnt_o <= lock_loss_cnt_o + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    io_debounce #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .RST_VAL      (CH_RST_VAL[g])
    ) u_debounce (
      .clk_i   (clk_i),
      .rst_n_i (rst_n),
      .ch_i    (ch_i[g]),
      .ch_o    (ch_o[g]),
      .rise_o  (rise_o[g]),
      .fall_o  (fall_o[g])
    );
  end

endmodule

// File: tb/tb_fpga_io_conditioner.sv
// Directed bench for fpga_io_conditioner: behavioural model compared every cycle plus literal timing checks.
module tb_fpga_io_conditioner;

  localparam int NUM_CH = 3;
  localparam int SYNC   = 2;
  localparam int DEB    = 4;
  localparam int HOLD   = 16;
  localparam logic [NUM_CH-1:0] RST_VAL = '0;

  logic              clk = 1'b0;
  logic              rst_n_i;
  logic              pll_locked_i;
  logic [NUM_CH-1:0] ch_i;
  logic [NUM_CH-1:0] ch_o, rise_o, fall_o;
  logic              sys_rst_n_o;
  logic [7:0]        lock_loss_cnt_o;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit chk_en = 1'b0;
  int rise_seen [NUM_CH];
  int fall_seen [NUM_CH];

  fpga_io_conditioner #(
    .NUM_CH       (NUM_CH),
    .SYNC_STAGES  (SYNC),
    .DEBOUNCE_CYC (DEB),
    .RST_HOLD_CYC (HOLD),
    .CH_RST_VAL   (RST_VAL)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n_i),
    .pll_locked_i    (pll_locked_i),
    .ch_i            (ch_i),
    .ch_o            (ch_o),
    .rise_o          (rise_o),
    .fall_o          (fall_o),
    .sys_rst_n_o     (sys_rst_n_o),
    .lock_loss_cnt_o (lock_loss_cnt_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Model: inputs seen SYNC edges late; run after HOLD+1 consecutive locked edges.
  bit                m_lpipe [SYNC];
  logic [NUM_CH-1:0] m_cpipe [SYNC];
  int                m_rcnt, m_lrun, m_loss;
  bit                m_run;
  logic [NUM_CH-1:0] m_q, m_rise, m_fall;
  int                m_len [NUM_CH];

  function automatic void model_reset();
    m_rcnt = 0; m_lrun = 0; m_loss = 0; m_run = 1'b0;
    m_q = RST_VAL; m_rise = '0; m_fall = '0;
    for (int k = 0; k < SYNC; k++) begin
      m_lpipe[k] = 1'b0;
      m_cpipe[k] = RST_VAL;
    end
    for (int i = 0; i < NUM_CH; i++) m_len[i] = 0;
  endfunction

  function automatic void model_step();
    logic              s_lock;
    logic [NUM_CH-1:0] s_ch;
    s_lock = m_lpipe[SYNC-1];
    s_ch   = m_cpipe[SYNC-1];
    if (m_run) begin
      if (!s_lock) begin
        m_run = 1'b0; m_lrun = 0;
        if (m_loss < 255) m_loss++;
      end
    end else if (s_lock) begin
      m_lrun++;
      if (m_lrun == HOLD + 1) begin m_run = 1'b1; m_lrun = 0; end
    end else begin
      m_lrun = 0;
    end
    m_rise = '0; m_fall = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (s_ch[i] != m_q[i]) begin
        m_len[i]++;
        if (m_len[i] == DEB) begin
          m_q[i] = s_ch[i]; m_len[i] = 0;
          if (s_ch[i]) m_rise[i] = 1'b1; else m_fall[i] = 1'b1;
        end
      end else begin
        m_len[i] = 0;
      end
    end
    for (int k = SYNC - 1; k > 0; k--) begin
      m_lpipe[k] = m_lpipe[k-1];
      m_cpipe[k] = m_cpipe[k-1];
    end
    m_lpipe[0] = pll_locked_i;
    m_cpipe[0] = ch_i;
  endfunction

  initial model_reset();

  always @(posedge clk) begin
    if (!rst_n_i)       model_reset();
    else if (m_rcnt < 2) m_rcnt++;
    else                model_step();
  end

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      check("ch_o", 32'(ch_o), 32'(m_q));
      check("rise_o", 32'(rise_o), 32'(m_rise));
      check("fall_o", 32'(fall_o), 32'(m_fall));
      check("sys_rst_n_o", 32'(sys_rst_n_o), 32'(m_run));
      check("lock_loss_cnt_o", 32'(lock_loss_cnt_o), 32'(m_loss));
      check("rise_fall_excl", 32'(|(rise_o & fall_o)), 0);
      for (int i = 0; i < NUM_CH; i++) begin
        if (rise_o[i] === 1'b1) rise_seen[i]++;
        if (fall_o[i] === 1'b1) fall_seen[i]++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic clear_seen();
    for (int i = 0; i < NUM_CH; i++) begin
      rise_seen[i] = 0;
      fall_seen[i] = 0;
    end
  endtask

  task automatic wait_sys(input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sys_rst_n_o === val) begin at = cyc; break; end
    end
    #1;
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_sys timeout: got %0b expected %0b", sys_rst_n_o, val);
    end
  endtask

  task automatic wait_ch(input int idx, input logic val, input int budget, output int at);
    at = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (ch_o[idx] === val) begin at = cyc; break; end
    end
    #1;
    if (at < 0) begin
      checks++; errors++;
      $display("FAIL wait_ch%0d timeout: got %0b expected %0b", idx, ch_o[idx], val);
    end
  endtask

  initial begin
    int p, at;
    rst_n_i = 1'b0; pll_locked_i = 1'b0; ch_i = RST_VAL;
    clear_seen();
    chk_en = 1'b1;
    tick(3);
    check("rst_sys_rst_n", 32'(sys_rst_n_o), 0);
    check("rst_ch_o", 32'(ch_o), 32'(RST_VAL));
    check("rst_loss_cnt", 32'(lock_loss_cnt_o), 0);
    check("rst_pulses", 32'(rise_o | fall_o), 0);
    rst_n_i = 1'b1;
    tick(7);

    p = cyc; pll_locked_i = 1'b1;
    wait_sys(1'b1, 60, at);
    check("lock_to_run_cycles", 32'(at - p), 19);
    check("loss_cnt_first_run", 32'(lock_loss_cnt_o), 0);
    tick(5);

    p = cyc; pll_locked_i = 1'b0;
    wait_sys(1'b0, 20, at);
    check("lock_drop_cycles", 32'(at - p), 3);
    check("loss_cnt_one", 32'(lock_loss_cnt_o), 1);
    tick(2);
    p = cyc; pll_locked_i = 1'b1;
    wait_sys(1'b1, 60, at);
    check("relock_to_run_cycles", 32'(at - p), 19);

    clear_seen();
    p = cyc; ch_i[1] = 1'b1;
    wait_ch(1, 1'b1, 20, at);
    check("ch1_rise_latency", 32'(at - p), 6);
    tick(3);
    check("ch1_rise_pulses", 32'(rise_seen[1]), 1);
    check("ch1_no_fall", 32'(fall_seen[1]), 0);
    check("ch0_ch2_idle", 32'({ch_o[2], ch_o[0]}), 0);
    check("ch0_ch2_no_pulse", 32'(rise_seen[0] + rise_seen[2] + fall_seen[0] + fall_seen[2]), 0);

    clear_seen();
    p = cyc; ch_i[1] = 1'b0;
    wait_ch(1, 1'b0, 20, at);
    check("ch1_fall_latency", 32'(at - p), 6);
    tick(3);
    check("ch1_fall_pulses", 32'(fall_seen[1]), 1);

    clear_seen();
    ch_i[0] = 1'b1;
    tick(3);
    ch_i[0] = 1'b0;
    tick(12);
    check("glitch_ch0_level", 32'(ch_o[0]), 0);
    check("glitch_ch0_pulses", 32'(rise_seen[0] + fall_seen[0]), 0);

    for (int n = 0; n < 300; n++) begin
      pll_locked_i = 1'b0;
      wait_sys(1'b0, 20, at);
      pll_locked_i = 1'b1;
      wait_sys(1'b1, 60, at);
    end
    check("loss_cnt_saturated", 32'(lock_loss_cnt_o), 255);

    ch_i[2] = 1'b1;
    tick(4);
    rst_n_i = 1'b0;
    #1;
    check("midrst_sys_rst_n", 32'(sys_rst_n_o), 0);
    check("midrst_ch_o", 32'(ch_o), 32'(RST_VAL));
    check("midrst_pulses", 32'(rise_o | fall_o), 0);
    check("midrst_loss_cnt", 32'(lock_loss_cnt_o), 0);
    ch_i = RST_VAL;
    tick(2);
    clear_seen();
    rst_n_i = 1'b1;
    tick(20);
    check("post_rst_ch_o", 32'(ch_o), 32'(RST_VAL));
    check("post_rst_no_pulse", 32'(rise_seen[0] + rise_seen[1] + rise_seen[2] + fall_seen[0] + fall_seen[1] + fall_seen[2]), 0);
    wait_sys(1'b1, 60, at);
    check("post_rst_loss_cnt", 32'(lock_loss_cnt_o), 0);

    tick(2);
    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
